// File: rtl/seq_shifter_if.sv
// Handshake/data bundle between a requester and seq_shifter.
// master drives the request, slave returns status and result.
interface seq_shifter_if #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
);
  logic               start;
  logic [WIDTH-1:0]   din;
  logic [SHAMT_W-1:0] shamt;
  logic               dir;
  logic               arith;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   dout;
  logic               carry;

  modport master (
    output start, din, shamt, dir, arith,
    input  busy, done, dout, carry
  );

  modport slave (
    input  start, din, shamt, dir, arith,
    output busy, done, dout, carry
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle SLL/SRL/SRA unit, one bit per clock with start/busy/done.
// SEQ_SHIFTER_FAST_EN: 4-bit steps while at least 4 bits remain.
module seq_shifter #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input logic         CLK,
  input logic         Reset,
  seq_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   sreg;
  logic [SHAMT_W-1:0] cnt;
  logic               dir_q;
  logic               arith_q;
  logic               busy_q;
  logic               done_q;
  logic               carry_q;

  logic               fill;
  logic [WIDTH-1:0]   step1;
  logic               c1;

  assign fill = arith_q & sreg[WIDTH-1];

  always_comb begin
    step1 = sreg;
    c1    = 1'b0;
    if (dir_q) begin
      step1 = {fill, sreg[WIDTH-1:1]};
      c1    = sreg[0];
    end else begin
      step1 = {sreg[WIDTH-2:0], 1'b0};
      c1    = sreg[WIDTH-1];
    end
  end

`ifdef SEQ_SHIFTER_FAST_EN
  logic [WIDTH-1:0] step4;
  logic [WIDTH-1:0] part3;
  logic             c4;
  logic             fast;

  assign fast = int'(cnt) >= 4;

  // carry is the last single bit out, i.e. the bit after a 3-bit shift
  always_comb begin
    step4 = sreg;
    part3 = sreg;
    c4    = 1'b0;
    if (dir_q) begin
      part3 = (sreg >> 3) | ({WIDTH{fill}} << (WIDTH - 3));
      step4 = (sreg >> 4) | ({WIDTH{fill}} << (WIDTH - 4));
      c4    = part3[0];
    end else begin
      part3 = sreg << 3;
      step4 = sreg << 4;
      c4    = part3[WIDTH-1];
    end
  end
`endif

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            sreg    <= bus.din;
            cnt     <= bus.shamt;
            dir_q   <= bus.dir;
            arith_q <= bus.arith;
            carry_q <= 1'b0;
            if (bus.shamt == '0) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state  <= SHIFT;
              busy_q <= 1'b1;
              done_q <= 1'b0;
            end
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        end
        SHIFT: begin
`ifdef SEQ_SHIFTER_FAST_EN
          if (fast) begin
            sreg    <= step4;
            carry_q <= c4;
            cnt     <= cnt - SHAMT_W'(4);
            if (int'(cnt) == 4) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end else begin
            sreg    <= step1;
            carry_q <= c1;
            cnt     <= cnt - SHAMT_W'(1);
            if (cnt == SHAMT_W'(1)) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
`else
          sreg    <= step1;
          carry_q <= c1;
          cnt     <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
`endif
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.dout  = sreg;
  assign bus.carry = carry_q;

endmodule
